regfile_param_2w2r: RTL and testbench

//  Parametrised 2-write / 2-read register file: next-generation core regfile.
//  - Registered reads with write-through bypass.
//  - Optional hardwired-zero register 0.
//  - Sequential clear engine: zeroes storage one entry per cycle after reset or on

---
 rtl/regfile_param_2w2r.sv | 121 ++++++++++++
 tb/tb_regfile_param_2w2r.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_2w2r.sv
// Two-write / two-read register file with registered, write-through reads and a
// sequential clear engine that zeroes the array one entry per cycle.
module regfile_param_2w2r #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid2
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              wr0_ok, wr1_ok;

  // An address is usable when it maps to real storage and is not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  assign idle   = (state == IDLE);
  assign busy   = (state == CLEAR);
  assign wr0_ok = idle && we0 && addr_ok(waddr0);
  assign wr1_ok = idle && we1 && addr_ok(waddr1);

  // Port 1 is checked first so it wins when both writers target the read address.
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    if (!addr_ok(a))                return '0;
    if (wr1_ok && (waddr1 == a))    return wdata1;
    if (wr0_ok && (waddr0 == a))    return wdata0;
    return mem[a];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        if (32'(ptr) == DEPTH - 1) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // NOTE: the array has no reset; the clear sweep zeroes it instead of fanning reset
  // out to every storage bit.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr] <= '0;
    end else begin
      if (wr0_ok) mem[waddr0] <= wdata0;
      if (wr1_ok) mem[waddr1] <= wdata1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata1  <= '0;
      rdata2  <= '0;
      rvalid1 <= 1'b0;
      rvalid2 <= 1'b0;
    end else begin
      rvalid1 <= idle && re1;
      rvalid2 <= idle && re2;
      if (idle && re1) rdata1 <= rd_val(raddr1);
      if (idle && re2) rdata2 <= rd_val(raddr2);
    end
  end

endmodule

// File: tb/tb_regfile_param_2w2r.sv
// Bench for regfile_param_2w2r: two instances (ZERO_REG=1 and 0) share stimulus and
// are scored against an array-based reference model through per-port queues.
module tb_regfile_param_2w2r;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_req = 1'b0;
  logic we0 = 1'b0, we1 = 1'b0, re1 = 1'b0, re2 = 1'b0;
  logic [ADDR_W-1:0] waddr0 = '0, waddr1 = '0, raddr1 = '0, raddr2 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;

  logic              busy_o [2];
  logic [DATA_W-1:0] rd [4];
  logic              rv [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int clear_left = DEPTH;
  logic [DATA_W-1:0] mdl [2][DEPTH];
  logic [DATA_W-1:0] last [4];
  exp_t exp_q [4][$];

  always #5 clk = ~clk;

  regfile_param_2w2r #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_o[0]),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re1(re1), .raddr1(raddr1), .rdata1(rd[0]), .rvalid1(rv[0]),
    .re2(re2), .raddr2(raddr2), .rdata2(rd[1]), .rvalid2(rv[1])
  );

  regfile_param_2w2r #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b0)) dut_n (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_o[1]),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re1(re1), .raddr1(raddr1), .rdata1(rd[2]), .rvalid1(rv[2]),
    .re2(re2), .raddr2(raddr2), .rdata2(rd[3]), .rvalid2(rv[3])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instance 0 has the hardwired zero register, instance 1 does not.
  function automatic bit wr_ok(input int z, input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((z == 0) && (a == '0));
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input int z, input logic [ADDR_W-1:0] a);
    if (!wr_ok(z, a)) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && wr_ok(z, waddr0) && waddr0 == a) return wdata0;
    return mdl[z][a];
  endfunction

  task automatic model_zero();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < DEPTH; i++) mdl[z][i] = '0;
  endtask

  task automatic model_edge();
    exp_t e;
    cyc++;
    if (rst) begin
      clear_left = DEPTH;
      return;
    end
    if (clear_left > 0) begin
      clear_left--;
      return;
    end
    for (int z = 0; z < 2; z++) begin
      e.cyc = cyc;
      if (re1) begin e.data = model_read(z, raddr1); exp_q[2*z].push_back(e); end
      if (re2) begin e.data = model_read(z, raddr2); exp_q[2*z+1].push_back(e); end
      if (we0 && wr_ok(z, waddr0)) mdl[z][waddr0] = wdata0;
      if (we1 && wr_ok(z, waddr1)) mdl[z][waddr1] = wdata1;
    end
    if (clr_req) begin
      clear_left = DEPTH;
      model_zero();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0; re1 = 1'b0; re2 = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last[k] = '0;
    end
    clear_left = DEPTH;
    model_zero();
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_rdata[%0d]", k), 32'(rd[k]), 32'h0);
      check($sformatf("reset_rvalid[%0d]", k), 32'(rv[k]), 32'h0);
    end
    check("reset_busy_z", 32'(busy_o[0]), 32'h1);
    check("reset_busy_n", 32'(busy_o[1]), 32'h1);
    repeat (hold) step();
    rst = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      re1 = 1'b1; raddr1 = ADDR_W'(i);
      re2 = 1'b1; raddr2 = ADDR_W'(DEPTH - 1 - i);
      step();
    end
    set_idle();
  endtask

  task automatic fill();
    for (int i = 1; i < DEPTH; i++) begin
      set_idle();
      we0 = 1'b1; waddr0 = ADDR_W'(i); wdata0 = DATA_W'(8'h10 + i);
      step();
    end
    set_idle();
  endtask

  // Monitor: pops the oldest expectation whenever a port presents rvalid.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (rv[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("spurious_rvalid[%0d]", k), 32'h1, 32'h0);
          end else begin
            exp_t e;
            e = exp_q[k].pop_front();
            check($sformatf("rdata[%0d]", k), 32'(rd[k]), 32'(e.data));
            check($sformatf("latency[%0d]", k), 32'(cyc), 32'(e.cyc));
            last[k] = e.data;
          end
        end else begin
          check($sformatf("hold[%0d]", k), 32'(rd[k]), 32'(last[k]));
        end
      end
      check("busy_z", 32'(busy_o[0]), 32'(clear_left > 0));
      check("busy_n", 32'(busy_o[1]), 32'(clear_left > 0));
    end
  end

  initial begin
    do_reset(2);
    repeat (DEPTH) step();
    read_all();

    // Write then read the same location on the next cycle.
    we0 = 1'b1; waddr0 = 3'd3; wdata0 = 8'h5A; step();
    set_idle(); re1 = 1'b1; raddr1 = 3'd3; step();

    // Same-address double write: port 1 must win.
    set_idle();
    we0 = 1'b1; waddr0 = 3'd4; wdata0 = 8'h11;
    we1 = 1'b1; waddr1 = 3'd4; wdata1 = 8'h22; step();
    set_idle(); re1 = 1'b1; raddr1 = 3'd4; re2 = 1'b1; raddr2 = 3'd4; step();

    // Write-through bypass against an older value.
    set_idle(); we0 = 1'b1; waddr0 = 3'd5; wdata0 = 8'h10; step();
    set_idle();
    we1 = 1'b1; waddr1 = 3'd5; wdata1 = 8'hC3;
    re2 = 1'b1; raddr2 = 3'd5; step();
    set_idle(); re1 = 1'b1; raddr1 = 3'd5; step();

    // Register 0: dropped on the ZERO_REG instance, kept on the other.
    set_idle(); we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'hFF; step();
    set_idle(); re1 = 1'b1; raddr1 = 3'd0; re2 = 1'b1; raddr2 = 3'd0; step();
    set_idle();

    // Clear sweep with writes and reads attempted while busy.
    fill();
    clr_req = 1'b1; step();
    clr_req = 1'b0;
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h77;
    re1 = 1'b1; raddr1 = 3'd2; clr_req = 1'b1;
    repeat (DEPTH) step();
    set_idle();
    read_all();

    // Reset in the middle of a sweep restarts it.
    fill();
    clr_req = 1'b1; step();
    set_idle(); repeat (3) step();
    do_reset(2);
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h77; re2 = 1'b1; raddr2 = 3'd2;
    repeat (DEPTH) step();
    set_idle();
    read_all();

    // Randomised traffic with occasional clear requests.
    for (int n = 0; n < 600; n++) begin
      clr_req = ($urandom_range(0, 39) == 0);
      we0 = $urandom_range(0, 1); waddr0 = ADDR_W'($urandom_range(0, DEPTH - 1)); wdata0 = DATA_W'($urandom);
      we1 = $urandom_range(0, 1); waddr1 = ADDR_W'($urandom_range(0, DEPTH - 1)); wdata1 = DATA_W'($urandom);
      re1 = $urandom_range(0, 1); raddr1 = ADDR_W'($urandom_range(0, DEPTH - 1));
      re2 = $urandom_range(0, 1); raddr2 = ADDR_W'($urandom_range(0, DEPTH - 1));
      step();
    end
    set_idle();
    repeat (DEPTH + 2) step();
    read_all();
    repeat (2) step();

    for (int k = 0; k < 4; k++)
      check($sformatf("drain[%0d]", k), 32'(exp_q[k].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
